// File: rtl/adc_sample_unpacker_if.sv
// Packed-word input and unpacked-sample output handshake bundle.
interface adc_sample_unpacker_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic [63:0]         i_data;
  logic                i_valid;
  logic                o_ready;
  logic [SAMPLE_W-1:0] o_sample;
  logic                o_sample_valid;
  logic                i_sample_ready;
  logic [1:0]          o_lane;

  // Unpacker side
  modport slave (
    input  i_data, i_valid, i_sample_ready,
    output o_ready, o_sample, o_sample_valid, o_lane
  );

  // Producer/consumer side
  modport master (
    output i_data, i_valid, i_sample_ready,
    input  o_ready, o_sample, o_sample_valid, o_lane
  );
endinterface

// File: rtl/adc_sample_unpacker.sv
// Buffers 64-bit ADC words in a small FIFO and streams them out one
// sample per cycle, lane 0 first, with sticky overflow and word counting.
module adc_sample_unpacker #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SAMPLE_W   = 16
) (
  input  logic                  i_125clk,
  input  logic                  i_rst,
  adc_sample_unpacker_if.slave  bus,
  input  logic                  i_clr_overflow,
  output logic                  o_overflow,
  output logic [15:0]           o_word_count
);

  localparam int unsigned LANES = 4;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [LANES-1:0][SAMPLE_W-1:0] word_t;
  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  word_t               r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_ready;
  state_t              r_state;
  word_t               r_hold;
  logic [1:0]          r_lane;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_sample_valid;
  logic                r_overflow;
  logic [15:0]         r_word_count;

  state_t              w_state_nxt;
  logic [1:0]          w_lane_nxt;
  logic [SAMPLE_W-1:0] w_sample_nxt;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_push;
  logic                w_drop;
  logic                w_pop;
  logic                w_empty;
  word_t               w_head;

  assign w_push  = bus.i_valid & r_ready;
  assign w_drop  = bus.i_valid & ~r_ready;
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge i_125clk) begin
    if (w_push) r_mem[r_wr_ptr] <= word_t'(bus.i_data);
  end

  // Occupancy after this edge's push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge i_125clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < CNT_W'(FIFO_DEPTH));
    end
  end

  // Unpacker state register
  always_ff @(posedge i_125clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, FIFO pop and next lane/sample selection
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_lane_nxt   = r_lane;
    w_sample_nxt = r_sample;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_lane_nxt   = 2'd0;
          w_sample_nxt = w_head[0];
          w_state_nxt  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.i_sample_ready) begin
          if (r_lane != 2'd3) begin
            w_lane_nxt   = r_lane + 2'd1;
            w_sample_nxt = r_hold[r_lane + 2'd1];
          end else if (!w_empty) begin
            // Chain straight into the next word without a bubble
            w_pop        = 1'b1;
            w_lane_nxt   = 2'd0;
            w_sample_nxt = w_head[0];
          end else begin
            w_state_nxt  = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Holding register and registered sample outputs
  always_ff @(posedge i_125clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hold         <= '0;
      r_lane         <= 2'd0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      if (w_pop) r_hold <= w_head;
      r_lane         <= w_lane_nxt;
      r_sample       <= w_sample_nxt;
      r_sample_valid <= (w_state_nxt == ST_EMIT);
    end
  end

  // Sticky overflow (drop beats clear) and accepted-word counter
  always_ff @(posedge i_125clk or negedge i_rst) begin
    if (!i_rst) begin
      r_overflow   <= 1'b0;
      r_word_count <= 16'd0;
    end else begin
      if (w_drop)              r_overflow <= 1'b1;
      else if (i_clr_overflow) r_overflow <= 1'b0;
      if (w_push) r_word_count <= r_word_count + 16'd1;
    end
  end

  assign bus.o_ready        = r_ready;
  assign bus.o_sample       = r_sample;
  assign bus.o_sample_valid = r_sample_valid;
  assign bus.o_lane         = r_lane;
  assign o_overflow         = r_overflow;
  assign o_word_count       = r_word_count;

endmodule

// File: tb/tb_adc_sample_unpacker.sv
// Scoreboard bench for adc_sample_unpacker: accepted words push four
// expected samples, the monitor pops them on each output handshake.
module tb_adc_sample_unpacker;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SAMPLE_W   = 16;

  typedef struct packed {
    logic [1:0]  lane;
    logic [15:0] sample;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clr_ovf;
  logic        ovf;
  logic [15:0] wcnt;

  adc_sample_unpacker_if #(.SAMPLE_W(SAMPLE_W)) bus ();

  adc_sample_unpacker #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .SAMPLE_W   (SAMPLE_W)
  ) dut (
    .i_125clk       (clk),
    .i_rst          (rst_n),
    .bus            (bus),
    .i_clr_overflow (clr_ovf),
    .o_overflow     (ovf),
    .o_word_count   (wcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_wcnt = 0;
  int          run = 0;
  int          max_run = 0;
  logic        stall_seen = 1'b0;
  logic [15:0] stall_sample = '0;
  logic [1:0]  stall_lane = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for one edge; the bench decides whether it must be taken
  task automatic drive_word(input logic [63:0] d, input logic exp_acc);
    bus.i_data  = d;
    bus.i_valid = 1'b1;
    check("o_ready", 64'(bus.o_ready), 64'(exp_acc));
    if (exp_acc) begin
      for (int l = 0; l < 4; l++) q.push_back(exp_t'({2'(l), d[l*16 +: 16]}));
      exp_wcnt++;
    end
    cycle();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && q.size() != 0; i++) cycle();
    check("drain", 64'(q.size() == 0), 64'd1);
    cycle();
  endtask

  // Output monitor: scoreboard compare, hold-stability and run-length tracking
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (stall_seen && bus.o_sample_valid) begin
        check("hold_sample", 64'(bus.o_sample), 64'(stall_sample));
        check("hold_lane", 64'(bus.o_lane), 64'(stall_lane));
      end
      stall_seen   = bus.o_sample_valid && !bus.i_sample_ready;
      stall_sample = bus.o_sample;
      stall_lane   = bus.o_lane;
      if (bus.o_sample_valid) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (bus.o_sample_valid && bus.i_sample_ready) begin
        if (q.size() == 0) begin
          check("spurious_sample", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("sample", 64'(bus.o_sample), 64'(e.sample));
          check("lane", 64'(bus.o_lane), 64'(e.lane));
        end
      end
    end else begin
      stall_seen = 1'b0;
      run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    clr_ovf            = 1'b0;
    bus.i_data         = '0;
    bus.i_valid        = 1'b0;
    bus.i_sample_ready = 1'b0;
    #12;
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_valid", 64'(bus.o_sample_valid), 64'd0);
    check("rst_sample", 64'(bus.o_sample), 64'd0);
    check("rst_lane", 64'(bus.o_lane), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_wcnt", 64'(wcnt), 64'd0);
    cycle();
    rst_n = 1'b1;

    // Single word, continuous ready, plus first-sample latency
    bus.i_sample_ready = 1'b1;
    drive_word(64'h0004_0003_0002_0001, 1'b1);
    check("lat_pre_valid", 64'(bus.o_sample_valid), 64'd0);
    cycle();
    check("lat_valid", 64'(bus.o_sample_valid), 64'd1);
    check("lat_lane", 64'(bus.o_lane), 64'd0);
    check("lat_sample", 64'(bus.o_sample), 64'h1);
    wait_drain(20);
    check("idle_after_word", 64'(bus.o_sample_valid), 64'd0);
    check("wcnt_1", 64'(wcnt), 64'(16'(exp_wcnt)));

    // Two words four cycles apart must stream without a gap
    max_run = 0;
    drive_word(64'h1A13_1A12_1A11_1A10, 1'b1);
    cycle(); cycle(); cycle();
    drive_word(64'h2B23_2B22_2B21_2B20, 1'b1);
    wait_drain(30);
    check("no_gap_run", 64'(max_run), 64'd8);
    check("wcnt_3", 64'(wcnt), 64'd3);

    // Stalled output: FIFO plus holding register fill, then a drop
    bus.i_sample_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      drive_word({16'(i), 16'h3C00 + 16'(i), 16'hC3C3, 16'h0300 + 16'(i)}, i < 5);
    check("ovf_set", 64'(ovf), 64'd1);
    check("wcnt_8", 64'(wcnt), 64'(16'(exp_wcnt)));

    // Drop and clear together: set wins; clear alone then takes effect
    clr_ovf = 1'b1;
    drive_word(64'hDEAD_DEAD_DEAD_DEAD, 1'b0);
    check("ovf_set_wins", 64'(ovf), 64'd1);
    cycle();
    check("ovf_cleared", 64'(ovf), 64'd0);
    clr_ovf = 1'b0;
    check("wcnt_after_drops", 64'(wcnt), 64'd8);
    bus.i_sample_ready = 1'b1;
    wait_drain(100);

    // Toggled downstream ready: each sample held, order preserved
    drive_word(64'h4444_3333_2222_1111, 1'b1);
    drive_word(64'h8888_7777_6666_5555, 1'b1);
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      bus.i_sample_ready = ~bus.i_sample_ready;
      cycle();
    end
    bus.i_sample_ready = 1'b1;
    wait_drain(10);

    // Reset while emitting lane 2 with another word queued
    bus.i_sample_ready = 1'b0;
    drive_word(64'h5D03_5D02_5D01_5D00, 1'b1);
    drive_word(64'h6E03_6E02_6E01_6E00, 1'b1);
    check("pre_rst_valid", 64'(bus.o_sample_valid), 64'd1);
    bus.i_sample_ready = 1'b1;
    cycle(); cycle();
    bus.i_sample_ready = 1'b0;
    check("pre_rst_lane2", 64'(bus.o_lane), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.o_sample_valid), 64'd0);
    check("mid_rst_sample", 64'(bus.o_sample), 64'd0);
    check("mid_rst_lane", 64'(bus.o_lane), 64'd0);
    check("mid_rst_ready", 64'(bus.o_ready), 64'd1);
    check("mid_rst_wcnt", 64'(wcnt), 64'd0);
    q.delete();
    exp_wcnt = 0;
    cycle(); cycle();
    rst_n = 1'b1;
    bus.i_sample_ready = 1'b1;
    drive_word(64'h7F03_7F02_7F01_7F00, 1'b1);
    cycle();
    check("post_rst_valid", 64'(bus.o_sample_valid), 64'd1);
    check("post_rst_lane", 64'(bus.o_lane), 64'd0);
    check("post_rst_sample", 64'(bus.o_sample), 64'h7F00);
    wait_drain(20);
    cycle(); cycle(); cycle();
    check("post_rst_idle", 64'(bus.o_sample_valid), 64'd0);
    check("post_rst_wcnt", 64'(wcnt), 64'(16'(exp_wcnt)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_sample_unpacker.md
ADC_SAMPLE_UNPACKER -- requirements
Module: adc_sample_unpacker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of 64-bit words buffered (power of 2, 2..16).
REQ-002 SHALL have parameter SAMPLE_W, default 16, the width of one unpacked sample; four samples form one 64-bit word.
REQ-003 SHALL have port i_125clk  input  1  the single clock; all logic rises on its positive edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_data  input  64  packed ADC word: sample0=[15:0], sample1=[31:16], sample2=[47:32], sample3=[63:48].
REQ-006 SHALL have port i_valid  input  1  i_data is valid this cycle.
REQ-007 SHALL have port o_ready  output  1  the block accepts a word this cycle.
REQ-008 SHALL have port o_sample  output  SAMPLE_W  current unpacked sample.
REQ-009 SHALL have port o_sample_valid  output  1  o_sample is valid.
REQ-010 SHALL have port i_sample_ready  input  1  downstream accepts o_sample.
REQ-011 SHALL have port o_lane  output  2  index (0..3) of o_sample within its source word.
REQ-012 SHALL have port o_overflow  output  1  sticky flag: a word was dropped.
REQ-013 SHALL have port i_clr_overflow  input  1  synchronous clear of o_overflow.
REQ-014 SHALL have port o_word_count  output  16  count of accepted words.

Function
REQ-015 Word accept SHALL occur on an edge where i_valid=1 and o_ready=1; the word is written to the FIFO tail.
REQ-016 o_ready SHALL be 1 exactly when the FIFO holds fewer than FIFO_DEPTH words; a pop in the same cycle does not raise o_ready while full.
REQ-017 Simultaneous push and pop when the FIFO is neither full nor empty SHALL both take effect, leaving occupancy unchanged.
REQ-018 The unpacker SHALL be a two-state FSM: IDLE (o_sample_valid=0) and EMIT (o_sample_valid=1).
REQ-019 In IDLE with FIFO non-empty, the next edge SHALL pop the head word into a holding register, set o_lane=0, and enter EMIT.
REQ-020 In EMIT, o_sample SHALL equal the o_lane slice of the holding register and SHALL hold stable until i_sample_ready=1.
REQ-021 In EMIT on a sample handshake with o_lane<3, the next edge SHALL increment o_lane.
REQ-022 In EMIT on a handshake with o_lane=3: FIFO non-empty -> pop next word, o_lane=0, stay EMIT with no bubble; FIFO empty -> go IDLE.
REQ-023 Latency: a word accepted at edge k into an empty, IDLE block SHALL produce o_sample_valid=1 with lane 0 after edge k+1.
REQ-024 An edge with i_valid=1 and o_ready=0 SHALL drop the word and set o_overflow=1.
REQ-025 i_clr_overflow=1 SHALL clear o_overflow on the next edge; if a drop occurs on the same edge, set SHALL win.
REQ-026 o_word_count SHALL increment by 1 per accepted word and wrap from 0xFFFF to 0x0000; dropped words are not counted.
REQ-027 Sustained throughput SHALL be one sample per cycle when i_sample_ready=1 continuously; input rate is at most one word per four cycles without loss.

Reset
REQ-028 While i_rst=0, SHALL force FSM=IDLE, FIFO empty, o_ready=1, o_sample=0, o_sample_valid=0, o_lane=0, o_overflow=0, o_word_count=0, independent of i_125clk.
REQ-029 Reset asserted mid-word SHALL discard the holding register and all FIFO contents; no partial word is emitted after release.
REQ-030 On the first edge after reset release, the block SHALL accept a word if i_valid=1.

Verification
REQ-031 Single word 0x0004_0003_0002_0001, i_sample_ready=1 -> o_sample 0x0001,0x0002,0x0003,0x0004 on consecutive cycles, o_lane 0..3, then o_sample_valid=0.
REQ-032 Back-to-back words W0,W1 (i_valid every 4th cycle, i_sample_ready=1) -> 8 contiguous samples with no gap, o_word_count=2.
REQ-033 i_sample_ready=0 with i_valid=1 every cycle -> after FIFO_DEPTH+1 accepts (4 FIFO + 1 holding) o_ready=0; next word sets o_overflow=1; o_word_count=5.
REQ-034 i_sample_ready toggled 1,0,1,0 -> each sample held while ready=0, output order unchanged, no duplicates or losses.
REQ-035 i_rst=0 pulse while in EMIT at o_lane=2 -> outputs at reset values immediately; after release, next word emits from lane 0.
REQ-036 Drop and i_clr_overflow on the same edge -> o_overflow=1; i_clr_overflow alone next edge -> o_overflow=0.
